// File: rtl/dcache_plru.sv
// Per-set tree pseudo-LRU for the 8-way, 64-set data cache: way-touch updates and registered victim queries.
// Build option DCACHE_PLRU_FWD_EN: a query sees same-cycle touches to its set (post-update tree).
module dcache_plru #(
  parameter int SETS = 64,
  parameter int WAYS = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hit_read2plru_valid,
  input  logic [$clog2(SETS)-1:0]   hit_read2plru_index,
  input  logic [$clog2(WAYS)-1:0]   hit_read2plru_way,
  input  logic                      hit_write2plru_valid,
  input  logic [$clog2(SETS)-1:0]   hit_write2plru_index,
  input  logic [$clog2(WAYS)-1:0]   hit_write2plru_way,
  input  logic                      refill2plru_valid,
  input  logic [$clog2(SETS)-1:0]   refill2plru_index,
  input  logic [$clog2(WAYS)-1:0]   refill2plru_way,
  input  logic                      ctrl2plru_victim_req,
  input  logic [$clog2(SETS)-1:0]   ctrl2plru_victim_index,
  output logic                      plru2ctrl_victim_valid,
  output logic [$clog2(WAYS)-1:0]   plru2ctrl_victim_way
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TB    = WAYS - 1;

  logic [SETS-1:0][TB-1:0] tree_q, tree_d;
  logic [TB-1:0]           q_tree;
  logic                    valid_q, valid_d;
  logic [WAY_W-1:0]        way_q, way_d;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [TB-1:0] touch(input logic [TB-1:0] t, input logic [WAY_W-1:0] w);
    logic [TB-1:0] r;
    int node;
    r    = t;
    node = 0;
    for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
      r[node] = ~w[lvl];
      node    = 2 * node + 1 + int'(w[lvl]);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] victim(input logic [TB-1:0] t);
    logic [WAY_W-1:0] v;
    int node;
    v    = '0;
    node = 0;
    for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
      v[lvl] = t[node];
      node   = 2 * node + 1 + int'(t[node]);
    end
    return v;
  endfunction

  // Same-set touches chain in priority order, so a later touch only overrides the bits it writes.
  always_comb begin
    tree_d = tree_q;
    if (hit_read2plru_valid)
      tree_d[hit_read2plru_index] = touch(tree_d[hit_read2plru_index], hit_read2plru_way);
    if (hit_write2plru_valid)
      tree_d[hit_write2plru_index] = touch(tree_d[hit_write2plru_index], hit_write2plru_way);
    if (refill2plru_valid)
      tree_d[refill2plru_index] = touch(tree_d[refill2plru_index], refill2plru_way);
  end

  always_comb begin
`ifdef DCACHE_PLRU_FWD_EN
    q_tree = tree_d[ctrl2plru_victim_index];
`else
    q_tree = tree_q[ctrl2plru_victim_index];
`endif
    valid_d = ctrl2plru_victim_req;
    way_d   = ctrl2plru_victim_req ? victim(q_tree) : way_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tree_q  <= '0;
      valid_q <= 1'b0;
      way_q   <= '0;
    end else begin
      tree_q  <= tree_d;
      valid_q <= valid_d;
      way_q   <= way_d;
    end
  end

  assign plru2ctrl_victim_valid = valid_q;
  assign plru2ctrl_victim_way   = way_q;
endmodule

// File: tb/tb_dcache_plru.sv
// Scoreboard bench for dcache_plru; reference keeps per-way last-touch stamps and walks toward the stale half.
module tb_dcache_plru;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rd_v = 1'b0, wr_v = 1'b0, rf_v = 1'b0, q_v = 1'b0;
  logic [5:0] rd_i = '0, wr_i = '0, rf_i = '0, q_i = '0;
  logic [2:0] rd_w = '0, wr_w = '0, rf_w = '0;
  logic       o_valid;
  logic [2:0] o_way;

  dcache_plru dut (
    .clock(clock), .reset(reset),
    .hit_read2plru_valid(rd_v), .hit_read2plru_index(rd_i), .hit_read2plru_way(rd_w),
    .hit_write2plru_valid(wr_v), .hit_write2plru_index(wr_i), .hit_write2plru_way(wr_w),
    .refill2plru_valid(rf_v), .refill2plru_index(rf_i), .refill2plru_way(rf_w),
    .ctrl2plru_victim_req(q_v), .ctrl2plru_victim_index(q_i),
    .plru2ctrl_victim_valid(o_valid), .plru2ctrl_victim_way(o_way)
  );

  always #5 clock = ~clock;

  typedef struct { int due; logic [2:0] way; } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  bit started = 1'b0;

  int unsigned stamp [64][8];
  int unsigned now_t = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Each tree node points away from the half holding the most recent touch below it; untouched -> lower half.
  function automatic logic [2:0] model_victim(input int s);
    int lo, size, half, bw;
    int unsigned best;
    lo = 0; size = 8;
    while (size > 1) begin
      half = size / 2; best = 0; bw = -1;
      for (int w = lo; w < lo + size; w++)
        if (stamp[s][w] > best) begin best = stamp[s][w]; bw = w; end
      if (bw >= 0 && bw < lo + half) lo = lo + half;
      size = half;
    end
    return 3'(lo);
  endfunction

  task automatic model_touches(input logic a, input int ai, input int aw,
                               input logic b, input int bi, input int bw,
                               input logic c, input int ci, input int cw);
    if (a) begin now_t++; stamp[ai][aw] = now_t; end
    if (b) begin now_t++; stamp[bi][bw] = now_t; end
    if (c) begin now_t++; stamp[ci][cw] = now_t; end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 8; w++) stamp[s][w] = 0;
  endtask

  // One cycle of stimulus; expected victim is pushed when the query is issued.
  task automatic drive(input logic rv, input int ri, input int rw,
                       input logic wv, input int wi, input int ww,
                       input logic fv, input int fi, input int fw,
                       input logic qv, input int qi, input logic rst);
    exp_t e;
    rd_v = rv; rd_i = 6'(ri); rd_w = 3'(rw);
    wr_v = wv; wr_i = 6'(wi); wr_w = 3'(ww);
    rf_v = fv; rf_i = 6'(fi); rf_w = 3'(fw);
    q_v = qv; q_i = 6'(qi); reset = rst;
    if (rst) model_reset();
    else begin
`ifdef DCACHE_PLRU_FWD_EN
      model_touches(rv, ri, rw, wv, wi, ww, fv, fi, fw);
      if (qv) begin e.due = cyc + 1; e.way = model_victim(qi); sb.push_back(e); end
`else
      if (qv) begin e.due = cyc + 1; e.way = model_victim(qi); sb.push_back(e); end
      model_touches(rv, ri, rw, wv, wi, ww, fv, fi, fw);
`endif
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(); drive(0,0,0, 0,0,0, 0,0,0, 0,0, 0); endtask
  task automatic query(input int qi); drive(0,0,0, 0,0,0, 0,0,0, 1,qi, 0); endtask
  task automatic touch1(input int s, input int w); drive(1,s,w, 0,0,0, 0,0,0, 0,0, 0); endtask

  task automatic check_reset_state(input string name);
    tests++;
    if (o_valid !== 1'b0 || o_way !== 3'd0) begin
      fails++;
      $display("FAIL %s: valid=%b way=%0d, required valid=0 way=0", name, o_valid, o_way);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        tests++; fails++;
        $display("FAIL missing_valid: no result in cycle %0d, required way=%0d", sb[0].due, sb[0].way);
        void'(sb.pop_front());
      end
      if (o_valid === 1'b1) begin
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL spurious_valid: valid=1 way=%0d in cycle %0d, required valid=0", o_way, cyc);
        end else begin
          e = sb.pop_front();
          if (e.due != cyc || o_way !== e.way) begin
            fails++;
            $display("FAIL victim: cycle %0d way=%0d, required cycle %0d way=%0d", cyc, o_way, e.due, e.way);
          end
        end
      end
    end
  end

  function automatic int pick_idx();
    case ($urandom_range(0, 4))
      0: return 5;
      1: return 63;
      2: return 0;
      3: return 6;
      default: return int'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    drive(0,0,0, 0,0,0, 0,0,0, 0,0, 1);
    drive(1,5,3, 1,9,1, 1,5,7, 1,5, 1);
    started = 1'b1;
    check_reset_state("reset_outputs");

    query(5); idle();
    touch1(5, 0); query(5);
    touch1(5, 4); query(5);

    drive(0,0,0, 0,0,0, 0,0,0, 0,0, 1);
    drive(1,5,0, 0,0,0, 1,5,4, 0,0, 0);
    query(5); query(6);

    touch1(63, 0); query(0); query(63);

    drive(0,0,0, 0,0,0, 0,0,0, 0,0, 1);
    drive(1,5,0, 0,0,0, 0,0,0, 1,5, 0);
    query(5);

    drive(1,10,3, 1,20,6, 1,30,1, 0,0, 0);
    drive(0,0,0, 0,0,0, 0,0,0, 1,10, 0);
    drive(0,0,0, 0,0,0, 0,0,0, 1,20, 1);
    check_reset_state("reset_mid_op");
    query(10); query(20); query(30);

    // Clustered indices force same-set collisions among touches and queries.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), pick_idx(), $urandom_range(0, 7),
            $urandom_range(0, 1), pick_idx(), $urandom_range(0, 7),
            $urandom_range(0, 1), pick_idx(), $urandom_range(0, 7),
            ($urandom_range(0, 9) < 6), pick_idx(), ($urandom_range(0, 99) == 0));
    end
    idle(); idle(); idle();

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
